// File: rtl/frogger_hpi_pkg.sv
// Shared types for the CY7C67200 HPI bus sequencer.
// Holds the FSM state enum, the HPI register map and the phase counter type.
package frogger_hpi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    // A phase of n cycles loads n-1 and ends when the counter reads 0.
    function automatic cnt_t phase_load(input int unsigned n);
        return cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/frogger_hpi_bus_seq_if.sv
// Avalon-MM slave bundle between the Nios II fabric and the HPI sequencer.
// master drives address/chipselect/read/write/writedata; slave returns readdata/waitrequest.
interface frogger_hpi_bus_seq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/frogger_hpi_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, reset_n (async, active-low), d (async in), q (synchronised out).
module frogger_hpi_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/frogger_hpi_bus_seq.sv
// Avalon-MM slave that turns single host accesses into timed HPI cycles
// (setup, strobe, hold, done, recovery), stalling the master with waitrequest.
// Ports: clk, reset_n (async, active-low); bus (Avalon slave modport);
//   otg_addr/otg_cs_n/otg_rd_n/otg_wr_n HPI pins; otg_data_out/otg_data_oe/
//   otg_data_in pad split; otg_int async HPI interrupt; irq level to Nios.
// Macro HPI_IRQ_SYNC_EN: when defined, otg_int is synchronised onto irq;
//   otherwise otg_int is ignored and irq is tied low.
module frogger_hpi_bus_seq
    import frogger_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 3,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    frogger_hpi_bus_seq_if.slave bus,
    output logic [1:0]           otg_addr,
    output logic                 otg_cs_n,
    output logic                 otg_rd_n,
    output logic                 otg_wr_n,
    output logic [15:0]          otg_data_out,
    output logic                 otg_data_oe,
    input  logic [15:0]          otg_data_in,
    input  logic                 otg_int,
    output logic                 irq
);

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_q, oe_d;
    logic        req;
    logic        last;
    logic        active_d;

    assign req  = bus.chipselect & (bus.read | bus.write);
    assign last = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    cnt_d   = phase_load(SETUP_CYC);
                    addr_d  = bus.address;
                    wdata_d = bus.writedata;
                    // read and write together resolve to a write
                    wr_d    = bus.write;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = STROBE;
                    cnt_d   = phase_load(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            STROBE: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = phase_load(HOLD_CYC);
                    if (!wr_q) rdata_d = otg_data_in;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            HOLD: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            DONE: begin
                state_d = RECOVER;
                cnt_d   = phase_load(RECOVER_CYC);
            end
            RECOVER: begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pad controls are registered from the next state so the pins are
        // glitch-free and line up exactly with the phase they belong to.
        active_d = state_d inside {SETUP, STROBE, HOLD};
        cs_n_d   = ~active_d;
        rd_n_d   = ~((state_d == STROBE) & ~wr_d);
        wr_n_d   = ~((state_d == STROBE) & wr_d);
        oe_d     = active_d & wr_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
        end
    end

    // DONE releases the master for one cycle; with no request it just passes.
    assign bus.waitrequest = req & (state_q != DONE);
    assign bus.readdata    = rdata_q;

    assign otg_addr     = addr_q;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_data_out = wdata_q;
    assign otg_data_oe  = oe_q;

`ifdef HPI_IRQ_SYNC_EN
    frogger_hpi_sync2 u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (otg_int),
        .q       (irq)
    );
`else
    logic unused_int;
    assign unused_int = otg_int;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_frogger_hpi_bus_seq.sv
// Directed bench for the HPI bus sequencer.
// Drives Avalon accesses, counts pin activity per cycle, checks hand-computed values.
module tb_frogger_hpi_bus_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  otg_addr;
    logic        otg_cs_n, otg_rd_n, otg_wr_n;
    logic [15:0] otg_data_out;
    logic        otg_data_oe;
    logic [15:0] otg_data_in;
    logic        otg_int = 1'b0;
    logic        irq;
    logic [15:0] pad_val = 16'h0000;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int n_wait, n_cs, n_wr, n_rd, n_ovl, n_oe;
    int first_cs, done_cyc;
    logic [15:0] rdata;
    logic done;

    frogger_hpi_bus_seq_if bus ();

    frogger_hpi_bus_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .otg_addr     (otg_addr),
        .otg_cs_n     (otg_cs_n),
        .otg_rd_n     (otg_rd_n),
        .otg_wr_n     (otg_wr_n),
        .otg_data_out (otg_data_out),
        .otg_data_oe  (otg_data_oe),
        .otg_data_in  (otg_data_in),
        .otg_int      (otg_int),
        .irq          (irq)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device drives the pad only while rd_n is low.
    assign otg_data_in = otg_rd_n ? 16'h0000 : pad_val;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 16'h0000;
    endtask

    task automatic access(input string tag, input logic [1:0] a,
                          input logic [15:0] wd, input logic r,
                          input logic w);
        n_wait = 0; n_cs = 0; n_wr = 0; n_rd = 0; n_ovl = 0; n_oe = 0;
        first_cs = -1; done_cyc = -1; done = 1'b0; rdata = '0;
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = wd;
        bus.chipselect = 1'b1;
        bus.read       = r;
        bus.write      = w;
        for (int n = 0; n < 24 && !done; n++) begin
            #1;
            if (bus.waitrequest) n_wait++;
            else begin
                done     = 1'b1;
                done_cyc = cyc;
                rdata    = bus.readdata;
            end
            if (!otg_cs_n) begin
                n_cs++;
                if (first_cs < 0) first_cs = cyc;
                if (otg_data_oe && otg_data_out == wd && otg_addr == a)
                    n_oe++;
            end
            if (!otg_wr_n) n_wr++;
            if (!otg_rd_n) n_rd++;
            if (!otg_wr_n && !otg_rd_n) n_ovl++;
            if (!done) @(negedge clk);
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        idle_bus();
    endtask

    int w_done;
    logic seen;

    initial begin
        idle_bus();
        repeat (2) @(negedge clk);
        chk("rst_cs_n", {31'd0, otg_cs_n}, 32'd1);
        chk("rst_rd_n", {31'd0, otg_rd_n}, 32'd1);
        chk("rst_wr_n", {31'd0, otg_wr_n}, 32'd1);
        chk("rst_oe", {31'd0, otg_data_oe}, 32'd0);
        chk("rst_addr", {30'd0, otg_addr}, 32'd0);
        chk("rst_dout", {16'd0, otg_data_out}, 32'd0);
        chk("rst_rdata", {16'd0, bus.readdata}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_wait", {31'd0, bus.waitrequest}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, default timing
        access("wr", 2'd2, 16'h1234, 1'b0, 1'b1);
        chk("wr_wait", n_wait, 32'd6);
        chk("wr_cs", n_cs, 32'd5);
        chk("wr_wr_n", n_wr, 32'd3);
        chk("wr_rd_n", n_rd, 32'd0);
        chk("wr_oe_data", n_oe, 32'd5);
        repeat (4) @(negedge clk);

        // Single read from DATA
        pad_val = 16'hBEEF;
        access("rd", 2'd0, 16'h0000, 1'b1, 1'b0);
        chk("rd_data", {16'd0, rdata}, 32'h0000BEEF);
        chk("rd_oe", n_oe, 32'd0);
        chk("rd_rd_n", n_rd, 32'd3);
        chk("rd_wr_n", n_wr, 32'd0);
        chk("rd_wait", n_wait, 32'd6);
        repeat (4) @(negedge clk);

        // Back-to-back write then read
        access("b2b_w", 2'd3, 16'hA55A, 1'b0, 1'b1);
        w_done = done_cyc;
        pad_val = 16'h0F0F;
        access("b2b_r", 2'd0, 16'h0000, 1'b1, 1'b0);
        chk("b2b_gap_ge3", {31'd0, (first_cs - w_done) >= 3}, 32'd1);
        chk("b2b_gap", first_cs - w_done, 32'd4);
        chk("b2b_ovl", n_ovl, 32'd0);
        chk("b2b_rdata", {16'd0, rdata}, 32'h00000F0F);
        repeat (4) @(negedge clk);

        // Reset pulsed mid-STROBE
        @(negedge clk);
        bus.address    = 2'd1;
        bus.writedata  = 16'h7777;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = !otg_wr_n;
        end
        chk("mid_strobe_seen", {31'd0, seen}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cs_n", {31'd0, otg_cs_n}, 32'd1);
        chk("arst_wr_n", {31'd0, otg_wr_n}, 32'd1);
        chk("arst_oe", {31'd0, otg_data_oe}, 32'd0);
        idle_bus();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        pad_val = 16'hC3C3;
        access("post_rst", 2'd0, 16'h0000, 1'b1, 1'b0);
        chk("post_rst_data", {16'd0, rdata}, 32'h0000C3C3);
        chk("post_rst_rd_n", n_rd, 32'd3);
        chk("post_rst_cs", n_cs, 32'd5);
        repeat (4) @(negedge clk);

        // read and write together at MAILBOX -> write
        access("rw", 2'd1, 16'h00AB, 1'b1, 1'b1);
        chk("rw_wr_n", n_wr, 32'd3);
        chk("rw_rd_n", n_rd, 32'd0);
        chk("rw_oe_data", n_oe, 32'd5);
        chk("rw_keep_rdata", {16'd0, bus.readdata}, 32'h0000C3C3);
        repeat (2) @(negedge clk);

        // Interrupt path
        @(negedge clk);
        otg_int = 1'b1;
`ifdef HPI_IRQ_SYNC_EN
        @(posedge clk); #1;
        chk("irq_edge1", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_edge2", {31'd0, irq}, 32'd1);
`else
        repeat (4) @(posedge clk);
        #1;
        chk("irq_tied", {31'd0, irq}, 32'd0);
`endif
        otg_int = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
